// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a two-entry skid buffer so the upstream ready is registered.
// Carries payload, bubble-cleared control, merged exception cause and delay-slot flag.
module pipe_stage_skid #(
    parameter int                    DATA_W      = 64,
    parameter int                    CTRL_W      = 16,
    parameter logic [CTRL_W-1:0]     CTRL_BUBBLE = {CTRL_W{1'b0}},
    parameter int                    CAUSE_W     = 5,
    parameter logic [CAUSE_W-1:0]    CAUSE_NONE  = 5'h1f,
    parameter logic [CAUSE_W-1:0]    CAUSE_ADEL  = 5'h04,
    parameter logic [CAUSE_W-1:0]    CAUSE_ADES  = 5'h05
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [CTRL_W-1:0]   i_ctrl,
    input  logic [CAUSE_W-1:0]  i_cause,
    input  logic                i_bad_addr,
    input  logic                i_dmem_we,
    input  logic                i_is_branch,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic [CTRL_W-1:0]   o_ctrl,
    output logic [CAUSE_W-1:0]  o_cause,
    output logic                o_in_delay_slot
);

    // state    | meaning
    // ST_EMPTY | main invalid, skid invalid
    // ST_ONE   | main valid, skid invalid
    // ST_FULL  | main and skid valid, upstream stalled
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ready_q;
    logic   last_br_q;

    logic                main_ds_q,  skid_ds_q;
    logic [DATA_W-1:0]   main_data_q, skid_data_q;
    logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
    logic [CAUSE_W-1:0]  main_cause_q, skid_cause_q;

    logic                accept, emit;
    logic [CAUSE_W-1:0]  in_cause;
    logic                load_main_in, load_main_skid, load_skid;

    assign accept   = i_valid & ready_q;
    assign emit     = (state_q != ST_EMPTY) & i_ready;
    assign in_cause = i_bad_addr ? (i_dmem_we ? CAUSE_ADES : CAUSE_ADEL) : i_cause;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = ST_FULL;
                        load_skid = 1'b1;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        state_d        = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            ready_q   <= 1'b1;
            last_br_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
            if (i_flush)
                last_br_q <= 1'b0;
            else if (accept)
                last_br_q <= i_is_branch;
        end
    end

    // Main entry drives the outputs; the skid only refills it, so order is preserved.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data_q  <= '0;
            main_ctrl_q  <= CTRL_BUBBLE;
            main_cause_q <= CAUSE_NONE;
            main_ds_q    <= 1'b0;
        end else if (load_main_in) begin
            main_data_q  <= i_data;
            main_ctrl_q  <= i_ctrl;
            main_cause_q <= in_cause;
            main_ds_q    <= last_br_q;
        end else if (load_main_skid) begin
            main_data_q  <= skid_data_q;
            main_ctrl_q  <= skid_ctrl_q;
            main_cause_q <= skid_cause_q;
            main_ds_q    <= skid_ds_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_data_q  <= '0;
            skid_ctrl_q  <= CTRL_BUBBLE;
            skid_cause_q <= CAUSE_NONE;
            skid_ds_q    <= 1'b0;
        end else if (load_skid) begin
            skid_data_q  <= i_data;
            skid_ctrl_q  <= i_ctrl;
            skid_cause_q <= in_cause;
            skid_ds_q    <= last_br_q;
        end
    end

    assign o_ready         = ready_q;
    assign o_valid         = (state_q != ST_EMPTY);
    assign o_data          = main_data_q;
    assign o_ctrl          = o_valid ? main_ctrl_q  : CTRL_BUBBLE;
    assign o_cause         = o_valid ? main_cause_q : CAUSE_NONE;
    assign o_in_delay_slot = o_valid & main_ds_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a FIFO-of-two reference model fed by
// directed and random traffic, with a negedge monitor comparing every cycle.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [63:0] i_data = '0;
    logic [15:0] i_ctrl = '0;
    logic [4:0]  i_cause = 5'h1f;
    logic        i_bad_addr = 1'b0;
    logic        i_dmem_we = 1'b0;
    logic        i_is_branch = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [63:0] o_data;
    logic [15:0] o_ctrl;
    logic [4:0]  o_cause;
    logic        o_in_delay_slot;

    pipe_stage_skid dut (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_ctrl(i_ctrl), .i_cause(i_cause), .i_bad_addr(i_bad_addr),
        .i_dmem_we(i_dmem_we), .i_is_branch(i_is_branch), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_ctrl(o_ctrl), .o_cause(o_cause), .o_in_delay_slot(o_in_delay_slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [15:0] ctrl;
        logic [4:0]  cause;
        logic        ds;
    } ent_t;

    ent_t        q[$];
    bit          m_last_br = 1'b0;
    bit          m_acc = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;
    logic [63:0] log_data[$];
    logic [4:0]  log_cause[$];
    logic        log_ds[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the stage behaves as an in-order queue of at most two entries.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            m_acc = 1'b0;
            if (reset || i_flush) begin
                q.delete();
                m_last_br = 1'b0;
            end else begin
                bit   rdy;
                bit   vld;
                ent_t e;
                rdy = (q.size() < 2);
                vld = (q.size() > 0);
                if (vld && i_ready) void'(q.pop_front());
                if (i_valid && rdy) begin
                    e.data  = i_data;
                    e.ctrl  = i_ctrl;
                    e.cause = i_bad_addr ? (i_dmem_we ? 5'h05 : 5'h04) : i_cause;
                    e.ds    = m_last_br;
                    q.push_back(e);
                    m_last_br = i_is_branch;
                    m_acc = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("o_valid", o_valid, q.size() > 0);
        chk("o_ready", o_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("o_data", o_data, q[0].data);
            chk("o_ctrl", o_ctrl, q[0].ctrl);
            chk("o_cause", o_cause, q[0].cause);
            chk("o_in_delay_slot", o_in_delay_slot, q[0].ds);
        end else begin
            chk("bubble_ctrl", o_ctrl, 16'h0);
            chk("bubble_cause", o_cause, 5'h1f);
            chk("bubble_ds", o_in_delay_slot, 1'b0);
        end
        if (o_valid && i_ready && !i_flush && !reset) begin
            log_data.push_back(o_data);
            log_cause.push_back(o_cause);
            log_ds.push_back(o_in_delay_slot);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [63:0] d, input logic br);
        i_valid     = v;
        i_data      = d;
        i_ctrl      = d[15:0] ^ 16'h5a5a;
        i_cause     = 5'h1f;
        i_bad_addr  = 1'b0;
        i_dmem_we   = 1'b0;
        i_is_branch = br;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_cause.delete();
        log_ds.delete();
    endtask

    initial begin
        logic [63:0] exp_d[$];

        // Reset held with an entry offered.
        drv(1'b1, 64'hAA, 1'b0);
        repeat (3) step();
        chk("reset_o_data", o_data, 64'h0);
        chk("reset_o_valid", o_valid, 1'b0);
        reset = 1'b0;
        step();
        chk("first_latency_valid", o_valid, 1'b1);
        chk("first_latency_data", o_data, 64'hAA);
        drv(1'b0, 64'h0, 1'b0);
        repeat (2) step();

        // Back-to-back stream.
        clear_log();
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 64'(i), 1'b0);
            step();
        end
        drv(1'b0, 64'h0, 1'b0);
        repeat (3) step();
        chk("stream_count", 64'(log_data.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_data.size(); i++)
            chk("stream_order", log_data[i], 64'(i));

        // Backpressure: A in main, B in skid, C held.
        clear_log();
        i_ready = 1'b0;
        drv(1'b1, 64'hA, 1'b0); step();
        drv(1'b1, 64'hB, 1'b0); step();
        drv(1'b1, 64'hC, 1'b0); step(); step();
        chk("stall_o_ready", o_ready, 1'b0);
        chk("stall_main", o_data, 64'hA);
        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (m_acc) break;
        end
        chk("c_accept_timeout", m_acc, 1'b1);
        drv(1'b0, 64'h0, 1'b0);
        repeat (4) step();
        exp_d = '{64'hA, 64'hB, 64'hC};
        chk("abc_count", 64'(log_data.size()), 64'd3);
        for (int i = 0; i < 3 && i < log_data.size(); i++)
            chk("abc_order", log_data[i], exp_d[i]);

        // Cause merge.
        clear_log();
        drv(1'b1, 64'h10, 1'b0); i_bad_addr = 1'b1; i_dmem_we = 1'b1; i_cause = 5'h0c; step();
        drv(1'b1, 64'h11, 1'b0); i_bad_addr = 1'b1; i_dmem_we = 1'b0; i_cause = 5'h1f; step();
        drv(1'b1, 64'h12, 1'b0); i_cause = 5'h0a; step();
        drv(1'b0, 64'h0, 1'b0);
        repeat (3) step();
        chk("cause_count", 64'(log_cause.size()), 64'd3);
        if (log_cause.size() == 3) begin
            chk("cause_ades", log_cause[0], 5'h05);
            chk("cause_adel", log_cause[1], 5'h04);
            chk("cause_pass", log_cause[2], 5'h0a);
        end

        // Delay slot after a branch.
        clear_log();
        drv(1'b1, 64'h20, 1'b1); step();
        drv(1'b1, 64'h21, 1'b0); step();
        drv(1'b1, 64'h22, 1'b0); step();
        drv(1'b0, 64'h0, 1'b0);
        repeat (3) step();
        chk("ds_count", 64'(log_ds.size()), 64'd3);
        if (log_ds.size() == 3) begin
            chk("ds_branch", log_ds[0], 1'b0);
            chk("ds_x", log_ds[1], 1'b1);
            chk("ds_y", log_ds[2], 1'b0);
        end

        // Flush between branch and X clears the delay-slot tracking.
        clear_log();
        drv(1'b1, 64'h30, 1'b1); step();
        drv(1'b0, 64'h0, 1'b0); i_flush = 1'b1; step();
        i_flush = 1'b0;
        drv(1'b1, 64'h31, 1'b0); step();
        drv(1'b1, 64'h32, 1'b0); step();
        drv(1'b0, 64'h0, 1'b0);
        repeat (3) step();
        chk("dsf_count", 64'(log_ds.size()), 64'd2);
        if (log_ds.size() == 2) begin
            chk("dsf_x_data", log_data[0], 64'h31);
            chk("dsf_x", log_ds[0], 1'b0);
            chk("dsf_y", log_ds[1], 1'b0);
        end

        // Flush while FULL with a new entry offered.
        i_ready = 1'b0;
        drv(1'b1, 64'h40, 1'b0); step();
        drv(1'b1, 64'h41, 1'b0); step();
        chk("full_o_ready", o_ready, 1'b0);
        drv(1'b1, 64'h42, 1'b0); i_flush = 1'b1; step();
        i_flush = 1'b0;
        drv(1'b0, 64'h0, 1'b0);
        chk("flush_o_valid", o_valid, 1'b0);
        chk("flush_o_ready", o_ready, 1'b1);
        chk("flush_o_ctrl", o_ctrl, 16'h0);
        clear_log();
        i_ready = 1'b1;
        repeat (5) step();
        chk("flush_nothing_emitted", 64'(log_data.size()), 64'd0);

        // Random traffic with occasional flush and asynchronous reset.
        for (int n = 0; n < 2500; n++) begin
            i_valid     = ($urandom_range(0, 3) != 0);
            i_ready     = ($urandom_range(0, 3) != 0);
            i_flush     = ($urandom_range(0, 39) == 0);
            i_data      = {$urandom, $urandom};
            i_ctrl      = 16'($urandom);
            i_cause     = 5'($urandom);
            i_bad_addr  = ($urandom_range(0, 3) == 0);
            i_dmem_we   = 1'($urandom);
            i_is_branch = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #3 reset = 1'b1;
                step();
                reset = 1'b0;
            end
            step();
        end

        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) step();
        chk("drained", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register: successor to the fixed per-field stage registers between ID/EXE/MEM/WB. Carries one opaque payload, one bubble-cleared control vector, an exception cause and a delay-slot flag through a valid/ready handshake. A two-entry skid buffer keeps the upstream ready signal registered. Flush kills everything in flight. Any stage boundary of the core can instantiate it.

## Interface
- DATA_W, 64: payload width (PC, instr, operands…); not cleared on bubble.
- CTRL_W, 16: control vector width (write-enables, branch/eret/trap flags); forced to CTRL_BUBBLE when empty/flushed.
- CTRL_BUBBLE, {CTRL_W{1'b0}}: control value presented while no valid entry.
- CAUSE_W, 5: exception cause width.
- CAUSE_NONE, 5'h1f: "no exception" cause code; also reset value.
- CAUSE_ADEL, 5'h04 / CAUSE_ADES, 5'h05: address-error load/store codes.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  kill all held entries; has priority over everything.
- i_valid  in  1  upstream entry offered.
- o_ready  out  1  stage can accept; registered.
- i_data  in  DATA_W  payload.
- i_ctrl  in  CTRL_W  control vector.
- i_cause  in  CAUSE_W  upstream exception cause.
- i_bad_addr  in  1  upstream detected misaligned data address.
- i_dmem_we  in  1  entry is a store (selects ADES vs ADEL).
- i_is_branch  in  1  entry is a branch/jump (for delay-slot tracking).
- o_valid  out  1  downstream entry valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DATA_W  payload.
- o_ctrl  out  CTRL_W  control vector (CTRL_BUBBLE when !o_valid).
- o_cause  out  CAUSE_W  exception cause (CAUSE_NONE when !o_valid).
- o_in_delay_slot  out  1  entry directly follows an accepted branch.

## Operation
- Accept = i_valid & o_ready; emit = o_valid & i_ready.
- Cause merge at accept: i_bad_addr ? (i_dmem_we ? CAUSE_ADES : CAUSE_ADEL) : i_cause.
- Delay slot: internal flag last_br updated on every accept to i_is_branch. The accepted entry's delay-slot bit = last_br before the update. last_br cleared by reset and flush.
- Storage: main entry (drives outputs) and skid entry, each holding data, ctrl, cause and ds.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- EMPTY: accept → ONE (main ← input).
- ONE:
  - accept & emit → ONE (main ← input).
  - accept & !emit → FULL (skid ← input).
  - emit only → EMPTY.
- FULL: emit → ONE (main ← skid). No accept possible, since o_ready=0.
- o_ready = (state != FULL), registered from next state.
- i_flush: next state EMPTY, last_br←0, o_ready←1. An accept in the same cycle is discarded. Outputs go to bubble values next cycle.
- When !o_valid: o_ctrl=CTRL_BUBBLE, o_cause=CAUSE_NONE, o_in_delay_slot=0. o_data holds its last value (don't-care).

## Timing
- Reset (async assert, sync-safe deassert) values:
  - o_valid=0, o_ready=1, o_ctrl=CTRL_BUBBLE, o_cause=CAUSE_NONE, o_in_delay_slot=0, o_data=0.
  - Skid cleared, last_br=0.
- Latency: 1 cycle input→output when not backpressured.
- Throughput: 1 entry/cycle sustained while i_ready=1.
- o_ready drops the cycle after the skid fills; one extra beat is absorbed without loss.
- No combinational path from i_ready to o_ready, or from i_valid to o_valid.
- Reset mid-operation: all held entries lost, no partial output.
- Flush and reset both dominate simultaneous accept/emit.
- Order preserved: main always older than skid.

## Test plan
- Reset with i_valid=1, then release → o_valid=0, o_ready=1, o_cause=5'h1f, o_ctrl=0 during reset; first entry appears 1 cycle after the first accept.
- Stream 8 entries (data=0..7), i_ready=1 → outputs 0..7 on consecutive cycles, o_ready constantly 1.
- i_ready=0 while streaming A,B,C:
  - A in main, B in skid.
  - o_ready=0 from the cycle after B is accepted; C held upstream.
  - Raise i_ready → output A,B,C in order, none dropped or duplicated.
- Accept a branch (i_is_branch=1), then X, then Y → X has o_in_delay_slot=1, Y has 0. Repeat with i_flush between branch and X → X has 0.
- i_bad_addr=1 with i_dmem_we=1 → o_cause=5'h05. With i_dmem_we=0 → 5'h04. With i_bad_addr=0, i_cause=5'h0a → 5'h0a.
- FULL state with i_flush=1 and i_valid=1 → next cycle o_valid=0, o_ready=1, o_ctrl=CTRL_BUBBLE. Neither held nor offered entry is ever emitted.
